// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI memory initiator: frame geometry, FSM encoding
// and a helper that packs the 16-bit command/data frame.
package spi_master_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 16;
    localparam logic        RW_READ    = 1'b1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCsSetup = 3'd1,
        StShift   = 3'd2,
        StCsHold  = 3'd3,
        StDone    = 3'd4
    } spi_state_e;

    // Frame is sent MSB first: address, then the read/write flag, then data.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ADDR_W-1:0] addr,
        input logic              rw,
        input logic [DATA_W-1:0] data
    );
        return {addr, rw, data};
    endfunction

endpackage

// File: rtl/spi_master_sclk_gen.sv
// Serial clock generator: counts half-periods of CLKDIV clk cycles and, when
// asked, toggles sclk at the end of each half-period. The same tick is reused
// by the initiator to time the chip-select setup and hold windows.
module spi_master_sclk_gen #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,      // counter runs while high, held at zero otherwise
    input  logic toggle,  // flip sclk on the tick that ends this half-period
    output logic sclk,
    output logic tick,    // last cycle of a half-period
    output logic rise,    // tick while sclk is low (next edge raises sclk)
    output logic fall     // tick while sclk is high (next edge lowers sclk)
);

    localparam logic [7:0] LastCount = 8'(CLKDIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;

    // Half-period counter and sclk level next-state
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        tick   = en && (cnt_q == LastCount);
        if (!en) begin
            cnt_d  = 8'd0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d = 8'd0;
            if (toggle) begin
                sclk_d = ~sclk_q;
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter and sclk state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;
    assign rise = tick && !sclk_q;
    assign fall = tick && sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator for the spiMemory frame: 7-bit address, read/write flag
// and one data byte, MSB first. Timing of sclk lives in spi_master_sclk_gen;
// the FSM, frame shifter and read capture live here.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned CLKDIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk_pin,
    output logic              cs_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);

    if (CLKDIV < 2 || CLKDIV > 255) begin : g_bad_clkdiv
        $error("spi_master: CLKDIV must be in 2..255");
    end

    spi_state_e state_q, state_d;

    logic [FRAME_BITS-1:0] frame_q;
    logic                  rw_q;
    logic [3:0]            bit_cnt_q;
    logic [DATA_W-1:0]     rx_q;
    logic [DATA_W-1:0]     rdata_q;

    logic gen_en, gen_toggle;
    logic sclk, tick, rise, fall;
    logic accept, shift_fall, shift_rise, finish;

    spi_master_sclk_gen #(
        .CLKDIV (CLKDIV)
    ) u_sclk_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (gen_en),
        .toggle (gen_toggle),
        .sclk   (sclk),
        .tick   (tick),
        .rise   (rise),
        .fall   (fall)
    );

    // Next-state and control strobes
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        gen_en     = 1'b0;
        gen_toggle = 1'b0;
        shift_fall = 1'b0;
        shift_rise = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StCsSetup;
                end
            end
            StCsSetup: begin
                // The tick ending setup raises sclk for the first frame bit.
                gen_en     = 1'b1;
                gen_toggle = 1'b1;
                if (tick) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                gen_en     = 1'b1;
                // Leave sclk low after the low phase of bit 0.
                gen_toggle = sclk || (bit_cnt_q != 4'd0);
                shift_fall = fall;
                shift_rise = rise;
                if (rise && bit_cnt_q == 4'd0) begin
                    state_d = StCsHold;
                end
            end
            StCsHold: begin
                gen_en = 1'b1;
                if (tick) begin
                    finish  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // A start held across DONE begins the next frame straight away,
                // so the only cs-high cycle between back-to-back frames is DONE.
                if (start) begin
                    accept  = 1'b1;
                    state_d = StCsSetup;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame shifter, bit counter and read capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q   <= '0;
            rw_q      <= 1'b0;
            bit_cnt_q <= 4'd0;
            rx_q      <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                frame_q   <= build_frame(addr, rw, wdata);
                rw_q      <= rw;
                bit_cnt_q <= 4'(FRAME_BITS - 1);
            end else if (shift_fall) begin
                // Zero fill leaves mosi low once bit 0 has been sent.
                frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
                if (rw_q == RW_READ && bit_cnt_q < 4'(DATA_W)) begin
                    rx_q <= {rx_q[DATA_W-2:0], miso_pin};
                end
            end
            if (shift_rise && bit_cnt_q != 4'd0) begin
                bit_cnt_q <= bit_cnt_q - 4'd1;
            end
            if (finish && rw_q == RW_READ) begin
                rdata_q <= rx_q;
            end
        end
    end

    assign busy     = (state_q == StCsSetup) || (state_q == StShift) || (state_q == StCsHold);
    assign done     = (state_q == StDone);
    assign cs_pin   = !busy;
    assign sclk_pin = sclk;
    assign mosi_pin = frame_q[FRAME_BITS-1];
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLKDIV=4 and CLKDIV=2) share one set of
// stimulus and a behavioural SPI memory; sel picks the active instance.
module tb_spi_master;

    typedef struct {
        int          accept;
        int          lat;
        int          cslow;
        logic [7:0]  rdata;
        logic [15:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       miso = 1'b0;
    logic       sel = 1'b0;

    logic       start_a, busy_a, done_a, sclk_a, cs_a, mosi_a;
    logic       start_b, busy_b, done_b, sclk_b, cs_b, mosi_b;
    logic [7:0] rdata_a, rdata_b;
    logic       busy, done, sclk, cs, mosi;
    logic [7:0] rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t        sb[$];
    logic [7:0]  mem[128];
    logic [7:0]  mrd[2];

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign busy    = sel ? busy_b  : busy_a;
    assign done    = sel ? done_b  : done_a;
    assign sclk    = sel ? sclk_b  : sclk_a;
    assign cs      = sel ? cs_b    : cs_a;
    assign mosi    = sel ? mosi_b  : mosi_a;
    assign rdata   = sel ? rdata_b : rdata_a;

    spi_master #(.CLKDIV(4)) u_dut_div4 (
        .clk(clk), .reset(reset), .start(start_a), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_a), .done(done_a), .rdata(rdata_a), .sclk_pin(sclk_a), .cs_pin(cs_a),
        .mosi_pin(mosi_a), .miso_pin(miso)
    );

    spi_master #(.CLKDIV(2)) u_dut_div2 (
        .clk(clk), .reset(reset), .start(start_b), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_b), .done(done_b), .rdata(rdata_b), .sclk_pin(sclk_b), .cs_pin(cs_b),
        .mosi_pin(mosi_b), .miso_pin(miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural SPI memory (mode 0) ----------------
    int          s_cnt = 0;
    logic        s_rd = 1'b0;
    logic [15:0] s_word = 16'h0;
    logic [7:0]  s_out = 8'h00;
    logic [15:0] last_frame;
    logic        force_pat = 1'b0;
    logic [7:0]  pat = 8'h00;

    always @(negedge cs) begin
        s_cnt      = 0;
        s_word     = 16'h0;
        s_rd       = 1'b0;
        miso       = 1'b0;
        last_frame = 16'hxxxx;
    end

    always @(posedge sclk) begin
        if (!cs) begin
            s_word = {s_word[14:0], mosi};
            s_cnt++;
            if (s_cnt == 8) begin
                s_rd  = s_word[0];
                s_out = force_pat ? pat : mem[s_word[7:1]];
            end
            if (s_cnt == 16) last_frame = s_word;
        end
    end

    always @(negedge sclk) begin
        #1;
        if (!cs && s_rd && s_cnt >= 8 && s_cnt < 16) miso = s_out[3'(15 - s_cnt)];
        else miso = 1'b0;
    end

    always @(posedge cs) begin
        if (s_cnt == 16 && !s_rd) mem[s_word[15:9]] = s_word[7:0];
    end

    // ---------------- monitor / scoreboard ----------------
    int   cs_low = 0;
    int   hi_run = 0;
    int   last_gap = 0;
    logic done_prev = 1'b0;
    exp_t m_e;

    always @(negedge clk) begin
        if (reset) begin
            cs_low    = 0;
            hi_run    = 0;
            done_prev = 1'b0;
        end else begin
            if (cs) hi_run++;
            else begin
                if (hi_run != 0) last_gap = hi_run;
                hi_run = 0;
                cs_low++;
            end
            if (done) begin
                chk("done_single_cycle", 32'(done_prev), 0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    m_e = sb.pop_front();
                    chk("done_latency", 32'(cyc + 1 - m_e.accept), 32'(m_e.lat));
                    chk("cs_low_cycles", 32'(cs_low), 32'(m_e.cslow));
                    chk("rdata", 32'(rdata), 32'(m_e.rdata));
                    chk("mosi_frame", 32'(last_frame), 32'(m_e.frame));
                end
                cs_low = 0;
            end
            done_prev = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input int acc, input logic t_rw, input logic [6:0] t_addr,
                            input logic [7:0] t_wdata);
        exp_t e;
        e.accept = acc;
        e.lat    = sel ? 69 : 137;
        e.cslow  = sel ? 68 : 136;
        e.rdata  = mrd[sel];
        e.frame  = {t_addr, t_rw, t_wdata};
        sb.push_back(e);
    endtask

    // Called at a negedge; start is seen at the following posedge.
    task automatic issue(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                         input logic [7:0] t_rd, output int acc);
        start = 1'b1;
        rw    = t_rw;
        addr  = t_addr;
        wdata = t_wdata;
        if (t_rw) mrd[sel] = t_rd;
        acc = cyc + 1;
        push_exp(acc, t_rw, t_addr, t_wdata);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                       input logic [7:0] t_rd);
        int acc;
        issue(t_rw, t_addr, t_wdata, t_rd, acc);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mrd[0] = 8'h00;
        mrd[1] = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_cs", 32'(cs), 1);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", 32'(rdata), 0);

        // Start on the first edge after reset release, then write / read back
        reset = 1'b0;
        txn(1'b0, 7'h2B, 8'hA5, 8'h00);
        chk("mem_2b", 32'(mem[7'h2B]), 32'h A5);
        txn(1'b1, 7'h2B, 8'h00, 8'hA5);

        // Read capture of a fixed miso pattern, then a write leaves rdata alone
        force_pat = 1'b1;
        pat       = 8'hC3;
        txn(1'b1, 7'h10, 8'h00, 8'hC3);
        force_pat = 1'b0;
        txn(1'b0, 7'h11, 8'h3C, 8'h00);

        // Start pulsed again 20 cycles into a frame is ignored
        issue(1'b0, 7'h05, 8'h5A, 8'h00, a);
        while (cyc < a + 19) @(negedge clk);
        start = 1'b1;
        rw    = 1'b1;
        addr  = 7'h7F;
        wdata = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start held high: two frames separated by a single cs-high cycle
        start = 1'b1;
        rw    = 1'b0;
        addr  = 7'h22;
        wdata = 8'h11;
        a     = cyc + 1;
        push_exp(a, 1'b0, 7'h22, 8'h11);
        push_exp(a + 137, 1'b0, 7'h22, 8'h11);
        while (cyc < a + 137) @(negedge clk);
        start = 1'b0;
        wait_drain();
        chk("b2b_cs_gap", 32'(last_gap), 1);

        // Reset 50 cycles into a frame aborts it immediately
        start = 1'b1;
        rw    = 1'b0;
        addr  = 7'h44;
        wdata = 8'h0F;
        a     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < a + 50) @(negedge clk);
        chk("pre_rst_cs", 32'(cs), 0);
        chk("pre_rst_busy", 32'(busy), 1);
        #1 reset = 1'b1;
        mrd[0] = 8'h00;
        mrd[1] = 8'h00;
        #1;
        chk("abort_cs", 32'(cs), 1);
        chk("abort_sclk", 32'(sclk), 0);
        chk("abort_mosi", 32'(mosi), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rdata", 32'(rdata), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        txn(1'b0, 7'h33, 8'h99, 8'h00);
        txn(1'b1, 7'h33, 8'h00, 8'h99);

        // Minimum divider
        sel = 1'b1;
        @(negedge clk);
        txn(1'b0, 7'h7F, 8'hFF, 8'h00);
        txn(1'b1, 7'h7F, 8'h00, 8'hFF);
        txn(1'b0, 7'h00, 8'h00, 8'h00);
        txn(1'b1, 7'h00, 8'h00, 8'h00);

        chk("idle_cs", 32'(cs), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_mosi", 32'(mosi), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
